// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control unit for the KGP-RISC datapath: FETCH/DECODE/EXEC/MEM/WB/DONE/HALT
// sequencing with registered Moore outputs, memory timeout, CALL link and CMOV gating.
module multicycle_ctrl_fsm #(
   parameter int OPCODE_W    = 6,
   parameter int FUNC_W      = 5,
   parameter int ALUOP_W     = 4,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [FUNC_W-1:0]   func,
   input  logic                int_req,
   input  logic                mem_ready,
   input  logic                cmov_cond,
   output logic [ALUOP_W-1:0]  alu_op,
   output logic [2:0]          br_op,
   output logic                alu_src,
   output logic                reg_alu_out,
   output logic                imm_sel,
   output logic                m_to_reg,
   output logic                rd_mem,
   output logic                wr_mem,
   output logic                wr_reg,
   output logic                upd_pc,
   output logic                call_link,
   output logic                illegal,
   output logic                mem_err,
   output logic                halted,
   output logic [2:0]          state_o
);
   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_DONE, S_HALT} state_t;
   typedef enum logic [2:0] {K_ALU, K_CMOV, K_BR, K_LD, K_ST, K_HALT, K_NOP} kind_t;
   typedef struct packed {
      logic [ALUOP_W-1:0] alu_op;
      logic [2:0]         br_op;
      logic               alu_src;
      logic               reg_alu_out;
      logic               imm_sel;
      logic               call_link;
      logic               bad;
   } steer_t;

   function automatic steer_t steer(input logic [OPCODE_W-1:0] op, input logic [3:0] fn);
      steer_t s;
      s = '0;
      if (op == '0) begin
         if (fn == 4'd0) s.bad = 1'b1;
         else begin
            s.alu_op      = ALUOP_W'(fn) - ALUOP_W'(1);
            s.alu_src     = 1'b1;
            s.reg_alu_out = 1'b1;
         end
      end else if (op <= OPCODE_W'(15)) s.alu_op = ALUOP_W'(op[3:0]) - ALUOP_W'(1);
      else if (op == OPCODE_W'(16)) s.alu_op = {ALUOP_W{1'b1}};
      else if (op == OPCODE_W'(20) || op == OPCODE_W'(21)) begin
         s.alu_src     = 1'b1;
         s.reg_alu_out = 1'b1;
      end else if (op == OPCODE_W'(17) || op == OPCODE_W'(18)) s.alu_op = '0;
      else if (op >= OPCODE_W'(32) && op <= OPCODE_W'(35)) begin
         s.br_op   = 3'(op[1:0]) + 3'd1;
         s.imm_sel = 1'b1;
      end else if (op == OPCODE_W'(38)) begin
         s.br_op     = 3'd1;
         s.imm_sel   = 1'b1;
         s.call_link = 1'b1;
      end else if (op != OPCODE_W'(36) && op != OPCODE_W'(37)) s.bad = 1'b1;
      return s;
   endfunction

   function automatic kind_t classify(input logic [OPCODE_W-1:0] op, input logic [3:0] fn);
      if (op == '0) return (fn == 4'd0) ? K_NOP : K_ALU;
      if (op <= OPCODE_W'(16) || op == OPCODE_W'(20) || op == OPCODE_W'(38)) return K_ALU;
      if (op == OPCODE_W'(21)) return K_CMOV;
      if (op == OPCODE_W'(17)) return K_LD;
      if (op == OPCODE_W'(18)) return K_ST;
      if (op >= OPCODE_W'(32) && op <= OPCODE_W'(35)) return K_BR;
      if (op == OPCODE_W'(36)) return K_HALT;
      return K_NOP;
   endfunction

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [OPCODE_W-1:0] ir_op;
   logic [FUNC_W-1:0]   ir_func;
   steer_t              s_in;
   kind_t               kind;
   logic                unused_func;

   assign s_in        = steer(opcode, func[3:0]);
   assign kind        = classify(ir_op, ir_func[3:0]);
   assign state_o     = state;
   assign unused_func = ^ir_func;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_FETCH;
         cnt         <= '0;
         ir_op       <= '0;
         ir_func     <= '0;
         alu_op      <= '0;
         br_op       <= '0;
         alu_src     <= 1'b0;
         reg_alu_out <= 1'b0;
         imm_sel     <= 1'b0;
         m_to_reg    <= 1'b0;
         rd_mem      <= 1'b0;
         wr_mem      <= 1'b0;
         wr_reg      <= 1'b0;
         upd_pc      <= 1'b0;
         call_link   <= 1'b0;
         illegal     <= 1'b0;
         mem_err     <= 1'b0;
         halted      <= 1'b0;
      end else begin
         illegal <= 1'b0;
         mem_err <= 1'b0;
         wr_reg  <= 1'b0;
         upd_pc  <= 1'b0;
         case (state)
            S_FETCH: begin
               ir_op       <= opcode;
               ir_func     <= func;
               alu_op      <= s_in.alu_op;
               br_op       <= s_in.br_op;
               alu_src     <= s_in.alu_src;
               reg_alu_out <= s_in.reg_alu_out;
               imm_sel     <= s_in.imm_sel;
               call_link   <= s_in.call_link;
               illegal     <= s_in.bad;
               state       <= S_DECODE;
            end
            S_DECODE: begin
               case (kind)
                  K_ALU, K_CMOV: begin
                     wr_reg <= (kind == K_ALU) | cmov_cond;
                     state  <= S_WB;
                  end
                  K_BR: state <= S_EXEC;
                  K_LD: begin
                     rd_mem <= 1'b1;
                     state  <= S_MEM;
                  end
                  K_ST: begin
                     wr_mem <= 1'b1;
                     state  <= S_MEM;
                  end
                  K_HALT: begin
                     halted <= 1'b1;
                     state  <= S_HALT;
                  end
                  default: begin
                     upd_pc <= 1'b1;
                     state  <= S_DONE;
                  end
               endcase
            end
            S_EXEC: begin
               upd_pc <= 1'b1;
               state  <= S_DONE;
            end
            // mem_ready is checked before the timeout so a late response still completes
            S_MEM: begin
               if (mem_ready) begin
                  cnt    <= '0;
                  rd_mem <= 1'b0;
                  wr_mem <= 1'b0;
                  if (kind == K_LD) begin
                     m_to_reg <= 1'b1;
                     wr_reg   <= 1'b1;
                     state    <= S_WB;
                  end else begin
                     upd_pc <= 1'b1;
                     state  <= S_DONE;
                  end
               end else if (cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                  cnt     <= '0;
                  rd_mem  <= 1'b0;
                  wr_mem  <= 1'b0;
                  mem_err <= 1'b1;
                  upd_pc  <= 1'b1;
                  state   <= S_DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_WB: begin
               upd_pc <= 1'b1;
               state  <= S_DONE;
            end
            S_DONE: begin
               alu_op      <= '0;
               br_op       <= '0;
               alu_src     <= 1'b0;
               reg_alu_out <= 1'b0;
               imm_sel     <= 1'b0;
               call_link   <= 1'b0;
               m_to_reg    <= 1'b0;
               state       <= S_FETCH;
            end
            S_HALT: begin
               if (int_req) begin
                  halted <= 1'b0;
                  upd_pc <= 1'b1;
                  state  <= S_DONE;
               end
            end
            default: state <= S_FETCH;
         endcase
      end
   end
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomised bench for multicycle_ctrl_fsm: per-instruction expected output traces built
// from the instruction-level rules, compared every cycle, plus literal pins.
module tb_multicycle_ctrl_fsm;
   localparam int T = 15;

   typedef struct packed {
      logic [3:0] alu_op;
      logic [2:0] br_op;
      logic alu_src, reg_alu_out, imm_sel, m_to_reg, rd_mem, wr_mem;
      logic wr_reg, upd_pc, call_link, illegal, mem_err, halted;
      logic [2:0] st;
   } out_t;

   logic       clk = 1'b0, rst_n = 1'b0;
   logic [5:0] opcode = '0;
   logic [4:0] func = '0;
   logic       int_req = 1'b0, mem_ready = 1'b0, cmov_cond = 1'b0;
   logic [3:0] alu_op;
   logic [2:0] br_op, state_o;
   logic alu_src, reg_alu_out, imm_sel, m_to_reg, rd_mem, wr_mem;
   logic wr_reg, upd_pc, call_link, illegal, mem_err, halted;

   always #5 clk = ~clk;

   multicycle_ctrl_fsm #(.OPCODE_W(6), .FUNC_W(5), .ALUOP_W(4), .MEM_TIMEOUT(T)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .int_req(int_req),
      .mem_ready(mem_ready), .cmov_cond(cmov_cond), .alu_op(alu_op), .br_op(br_op),
      .alu_src(alu_src), .reg_alu_out(reg_alu_out), .imm_sel(imm_sel), .m_to_reg(m_to_reg),
      .rd_mem(rd_mem), .wr_mem(wr_mem), .wr_reg(wr_reg), .upd_pc(upd_pc),
      .call_link(call_link), .illegal(illegal), .mem_err(mem_err), .halted(halted),
      .state_o(state_o));

   out_t act;
   assign act = {alu_op, br_op, alu_src, reg_alu_out, imm_sel, m_to_reg, rd_mem, wr_mem,
                 wr_reg, upd_pc, call_link, illegal, mem_err, halted, state_o};

   int   n_chk = 0, n_fail = 0;
   out_t exp_q[$];
   out_t obs[$];
   out_t exp_cur;
   bit   exp_vld = 1'b0;

   always @(negedge clk) begin
      if (exp_vld) begin
         n_chk++;
         obs.push_back(act);
         if (act !== exp_cur) begin
            n_fail++;
            $display("FAIL trace t=%0t: got %h expected %h", $time, act, exp_cur);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, a, e);
      end
   endtask

   // Expected trace of one instruction, FETCH through DONE.
   // k: cycles mem_ready stays low in MEM; w: HALT cycles before int_req.
   task automatic build(input logic [5:0] op, input logic [4:0] fn, input int k, input int w,
                        input bit cond);
      out_t s, r;
      bit   bad;
      int   kind;  // 0 reg-write, 1 branch, 2 load, 3 store, 4 halt, 5 retire-only
      int   n;
      s = '0; bad = 0; kind = 5;
      if (op == 0) begin
         if (fn[3:0] == 0) bad = 1;
         else begin s.alu_op = fn[3:0] - 4'd1; s.alu_src = 1; s.reg_alu_out = 1; kind = 0; end
      end else if (op <= 15) begin s.alu_op = op[3:0] - 4'd1; kind = 0; end
      else if (op == 16) begin s.alu_op = 4'hF; kind = 0; end
      else if (op == 20 || op == 21) begin s.alu_src = 1; s.reg_alu_out = 1; kind = 0; end
      else if (op == 17) kind = 2;
      else if (op == 18) kind = 3;
      else if (op >= 32 && op <= 35) begin s.br_op = 3'(op - 31); s.imm_sel = 1; kind = 1; end
      else if (op == 38) begin s.br_op = 1; s.imm_sel = 1; s.call_link = 1; kind = 0; end
      else if (op == 36) kind = 4;
      else if (op != 37) bad = 1;
      exp_q.delete();
      r = '0; exp_q.push_back(r);
      r = s; r.illegal = bad; r.st = 1; exp_q.push_back(r);
      case (kind)
         0: begin
            r = s; r.st = 4; r.wr_reg = (op == 21) ? cond : 1'b1; exp_q.push_back(r);
         end
         1: begin r = s; r.st = 2; exp_q.push_back(r); end
         2, 3: begin
            n = (k < T) ? k + 1 : T;
            for (int i = 0; i < n; i++) begin
               r = s; r.st = 3; r.rd_mem = (kind == 2); r.wr_mem = (kind == 3); exp_q.push_back(r);
            end
            if (k < T && kind == 2) begin
               r = s; r.st = 4; r.m_to_reg = 1; r.wr_reg = 1; exp_q.push_back(r);
               s.m_to_reg = 1;
            end
         end
         4: for (int i = 0; i <= w; i++) begin
            r = '0; r.st = 6; r.halted = 1; exp_q.push_back(r);
         end
         default: ;
      endcase
      r = s; r.st = 5; r.upd_pc = 1; r.mem_err = (kind == 2 || kind == 3) && k >= T;
      exp_q.push_back(r);
   endtask

   task automatic run(input logic [5:0] op, input logic [4:0] fn, input int k, input int w,
                      input bit cond);
      bit memop;
      build(op, fn, k, w, cond);
      obs.delete();
      memop = (op == 17 || op == 18);
      for (int c = 0; c < exp_q.size(); c++) begin
         opcode    = (c == 0) ? op : 6'($urandom);
         func      = (c == 0) ? fn : 5'($urandom);
         cmov_cond = (op == 21) ? cond : 1'($urandom);
         mem_ready = memop ? ((c >= 2 + k) || (c < 2 && 1'($urandom))) : 1'($urandom);
         int_req   = (op == 36) ? ((c == 2 + w) || (c < 2 && 1'($urandom))) : 1'($urandom);
         exp_cur   = exp_q[c];
         exp_vld   = 1'b1;
         @(posedge clk); #1;
      end
      exp_vld = 1'b0;
   endtask

   function automatic int count(input int f);
      int n = 0;
      foreach (obs[i]) begin
         case (f)
            0: n += int'(obs[i].rd_mem);
            1: n += int'(obs[i].wr_reg);
            2: n += int'(obs[i].halted);
            3: n += int'(obs[i].illegal);
            4: n += int'(obs[i].upd_pc);
            default: n += int'(obs[i].wr_mem);
         endcase
      end
      return n;
   endfunction

   initial begin
      logic [5:0] legal [16] = '{6'd0, 6'd1, 6'd7, 6'd15, 6'd16, 6'd17, 6'd18, 6'd20,
                                 6'd21, 6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38};
      logic [5:0] op;
      int k;

      // model pins
      build(6'd17, 5'd0, 2, 0, 1'b0);
      chk("model_ld_len", exp_q.size(), 7);
      build(6'd18, 5'd0, 0, 0, 1'b0);
      chk("model_st_len", exp_q.size(), 4);
      build(6'd36, 5'd0, 0, 5, 1'b0);
      chk("model_halt_len", exp_q.size(), 9);

      @(posedge clk); #1;
      chk("reset_outputs", 32'(act), 0);
      rst_n = 1'b1;

      // reset asserted mid-load
      opcode = 6'd17; func = '0; mem_ready = 1'b0; int_req = 1'b0;
      for (int c = 0; c < 3; c++) begin @(posedge clk); #1; end
      chk("mid_ld_rd_mem", rd_mem, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_ld_rst_rd_mem", rd_mem, 0);
      chk("mid_ld_rst_state", state_o, 0);
      chk("mid_ld_rst_all", 32'(act), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      run(6'd37, 5'd0, 0, 0, 1'b0);
      chk("resume_nop_len", obs.size(), 3);

      run(6'd1, 5'd9, 0, 0, 1'b0);
      chk("addi_alu_op", obs[1].alu_op, 0);
      chk("addi_alu_src", obs[1].alu_src, 0);
      chk("addi_wr_reg", obs[2].wr_reg, 1);
      chk("addi_upd_pc", obs[3].upd_pc, 1);
      run(6'd0, 5'd5, 0, 0, 1'b0);
      chk("rtype_alu_op", obs[1].alu_op, 4);
      chk("rtype_reg_alu_out", obs[1].reg_alu_out, 1);

      run(6'd17, 5'd0, 2, 0, 1'b0);
      chk("ld_rd_cycles", count(0), 3);
      chk("ld_m_to_reg", obs[5].m_to_reg, 1);
      chk("ld_wr_reg", obs[5].wr_reg, 1);
      run(6'd17, 5'd0, T + 5, 0, 1'b0);
      chk("ld_to_rd_cycles", count(0), T);
      chk("ld_to_mem_err", obs[T + 2].mem_err, 1);
      chk("ld_to_upd_pc", obs[T + 2].upd_pc, 1);
      chk("ld_to_no_wr", count(1), 0);
      run(6'd18, 5'd0, T - 1, 0, 1'b0);
      chk("st_late_ready_no_err", obs[T + 2].mem_err, 0);

      run(6'd21, 5'd0, 0, 0, 1'b0);
      chk("cmov0_no_wr", count(1), 0);
      chk("cmov0_upd_pc", count(4), 1);
      run(6'd21, 5'd0, 0, 0, 1'b1);
      chk("cmov1_wr", obs[2].wr_reg, 1);
      run(6'd38, 5'd0, 0, 0, 1'b0);
      chk("call_link", obs[1].call_link, 1);
      chk("call_br_op", obs[1].br_op, 1);
      chk("call_wr_reg", obs[2].wr_reg, 1);

      run(6'd36, 5'd0, 0, 19, 1'b0);
      chk("halt_cycles", count(2), 20);
      chk("halt_wake_upd_pc", obs[22].upd_pc, 1);
      chk("halt_wake_halted", obs[22].halted, 0);

      run(6'h3F, 5'd0, 0, 0, 1'b0);
      chk("illegal_pulse", obs[1].illegal, 1);
      chk("illegal_once", count(3), 1);
      chk("illegal_no_wr", count(1) + count(5), 0);
      chk("illegal_len", obs.size(), 3);
      run(6'd0, 5'd16, 0, 0, 1'b0);
      chk("rtype_f0_illegal", count(3), 1);

      for (int i = 0; i < 200; i++) begin
         op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legal[$urandom_range(0, 15)];
         k  = ($urandom_range(0, 5) == 0) ? $urandom_range(T - 1, T + 2) : $urandom_range(0, 4);
         run(op, 5'($urandom), k, $urandom_range(0, 6), 1'($urandom));
         if (count(4) != 1) chk("rand_one_upd_pc", count(4), 1);
      end

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Parametrised multicycle control unit for the KGP-RISC datapath. It decodes opcode/func into ALU, branch, memory and register-file controls across explicit FETCH/DECODE/MEM/WB/DONE phases. It adds the following capabilities:
- async active-low reset
- memory ready handshake with timeout
- CALL link write and CMOV condition
- illegal-opcode flag
- HALT exit on interrupt; NOP retires and does not hang

Parameters:
OPCODE_W, 6, opcode field width
FUNC_W, 5, func field width (ALU sel uses func[3:0])
ALUOP_W, 4, ALU operation code width
MEM_TIMEOUT, 15, max cycles in MEM waiting for mem_ready before abort (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  OPCODE_W  instruction opcode, valid during S_FETCH
func  in  FUNC_W  R-type function field, valid during S_FETCH
int_req  in  1  interrupt request, wakes HALT
mem_ready  in  1  data memory access complete
cmov_cond  in  1  CMOV write-enable condition from datapath
alu_op  out  ALUOP_W  ALU operation select
br_op  out  3  000 none, 001 BR/CALL, 010 BMI, 011 BPL, 100 BZ
alu_src, reg_alu_out, imm_sel, m_to_reg  out  1  datapath steering
rd_mem, wr_mem, wr_reg, upd_pc  out  1  strobes
call_link  out  1  register-write source = PC+1, destination = link reg
illegal  out  1  one-cycle pulse on undefined opcode/func
mem_err  out  1  one-cycle pulse on memory timeout
halted  out  1  high while in S_HALT
state_o  out  3  current state, for debug

Behaviour:
- States, encoded 0..6: S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_DONE, S_HALT.
- Reset (async, rst_n=0):
  - state=S_FETCH, wait counter=0, latched opcode/func=0.
  - All outputs 0 immediately, including mid-MEM strobes.
- Outputs are Moore: decoded from the state register plus the latched instruction register. No output glitches on opcode changes outside S_FETCH.
- opcode/func are latched on the edge leaving S_FETCH.
- S_FETCH: all outputs 0 -> S_DECODE.
- S_DECODE: steering outputs are driven from the latched instruction and held until S_DONE exits.
  - R_TYPE (0): alu_op=func[3:0]-1, alu_src=1, reg_alu_out=1 -> S_WB. func[3:0]=0 is illegal.
  - I-ALU (1..15): alu_op=opcode[3:0]-1, alu_src=0, imm_sel=0 -> S_WB.
  - LUI (16): alu_op=4'hF -> S_WB.
  - MOVE (20): alu_op=0, alu_src=1, reg_alu_out=1 -> S_WB.
  - CMOV (21): as MOVE; wr_reg in S_WB is gated by cmov_cond.
  - LD (17), ST (18): alu_op=0, alu_src=0, imm_sel=0 -> S_MEM.
  - BR/BMI/BPL/BZ (32..35): br_op=001/010/011/100, imm_sel=1 -> S_EXEC.
  - CALL (38): br_op=001, imm_sel=1, call_link=1 -> S_WB.
  - HALT (36) -> S_HALT.
  - NOP (37) -> S_DONE.
  - Any other code: illegal=1 for this cycle, then treated as NOP -> S_DONE.
- S_EXEC: one cycle, branch controls stable -> S_DONE.
- S_MEM:
  - rd_mem (LD) or wr_mem (ST) is held high; the counter increments each cycle.
  - mem_ready=1 sampled: LD -> S_WB with m_to_reg=1; ST -> S_DONE. Counter clears.
  - Counter reaches MEM_TIMEOUT with no mem_ready: strobe drops, mem_err=1 for one cycle, -> S_DONE with no writeback.
  - mem_ready in the same cycle as the timeout: mem_ready wins.
- S_WB: wr_reg=1 for exactly one cycle (for CMOV, wr_reg=cmov_cond) -> S_DONE.
- S_DONE: upd_pc=1 for exactly one cycle; all strobes 0 -> S_FETCH.
- S_HALT:
  - halted=1, all strobes 0; stays until int_req=1 is sampled -> S_DONE.
  - int_req outside S_HALT is ignored.
- Latency in cycles, FETCH to FETCH:
  - ALU/LUI/MOVE/CMOV/CALL: 4
  - branch: 4
  - NOP/illegal: 3
  - LD: 5+k and ST: 4+k, where k = cycles until mem_ready (k>=0 with mem_ready already high)
  - HALT: 3 + cycles waiting for int_req
- Exactly one upd_pc pulse per instruction, including aborted and illegal ones.

Test Plan:
- Reset mid-LD: assert rst_n=0 while rd_mem=1 -> rd_mem=0 that cycle, state_o=0; after release, FETCH resumes.
- ADDI (opcode=1): expect alu_op=0, alu_src=0; wr_reg pulses at cycle 3 and upd_pc at cycle 4; then R_TYPE func=5 -> alu_op=4, reg_alu_out=1.
- LD with mem_ready delayed 3 cycles -> rd_mem high exactly 3 cycles then m_to_reg=1 with wr_reg=1; mem_ready tied low with MEM_TIMEOUT=15 -> mem_err pulse at the 15th MEM cycle, no wr_reg, upd_pc follows.
- CMOV with cmov_cond=0 -> no wr_reg, upd_pc still pulses; cmov_cond=1 -> wr_reg pulse. CALL (38) -> call_link=1, br_op=001, wr_reg pulse.
- HALT (36): halted stays high for 20 cycles; int_req pulse -> upd_pc next cycle, halted=0; int_req during ADDI has no effect.
- Opcode 6'h3F -> illegal one-cycle pulse, no wr_reg/wr_mem; NOP (37) retires in 3 cycles and does not hang.
